// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port: buffers a payload, then
// sends header, payload and parity, holding bytes while the router is busy.
module router_pkt_tx #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic [5:0] len,
    input  logic       pl_wr,
    input  logic [7:0] pl_data,
    input  logic       busy,
    input  logic       err,
    output logic       packet_valid,
    output logic [7:0] pkt_data,
    output logic       ready,
    output logic       done,
    output logic       reject,
    output logic       err_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] len_q, len_d;
    logic [5:0] wr_idx_q, wr_idx_d;
    logic [5:0] rd_idx_q, rd_idx_d;
    logic [7:0] hdr_q, hdr_d;
    logic [7:0] par_q, par_d;
    logic [3:0] gap_q, gap_d;
    logic       pv_d;
    logic [7:0] data_d;
    logic       ready_d;
    logic       done_d;
    logic       reject_d;
    logic       err_flag_d;

    logic [7:0] mem [64];

    // Payload storage is plain memory; it needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && pl_wr) begin
            mem[wr_idx_q] <= pl_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        hdr_d      = hdr_q;
        par_d      = par_q;
        gap_d      = gap_q;
        err_flag_d = err_flag;
        done_d     = 1'b0;
        reject_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != 6'd0 && dest != 2'd3) begin
                        len_d      = len;
                        hdr_d      = {len, dest};
                        par_d      = {len, dest};
                        wr_idx_d   = 6'd0;
                        err_flag_d = 1'b0;
                        state_d    = S_LOAD;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (pl_wr) begin
                    par_d    = par_q ^ pl_data;
                    wr_idx_d = wr_idx_q + 6'd1;
                    if (wr_idx_q == len_q - 6'd1) begin
                        state_d = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    rd_idx_d = 6'd0;
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    rd_idx_d = rd_idx_q + 6'd1;
                    if (rd_idx_q == len_q - 6'd1) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    gap_d   = 4'(GAP_CYCLES);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (err) begin
                    err_flag_d = 1'b1;
                end
                if (gap_q <= 4'd1) begin
                    gap_d   = 4'd0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are a function of the state being entered, so they
        // register in step with it.
        pv_d    = 1'b0;
        data_d  = 8'h00;
        ready_d = 1'b0;
        unique case (state_d)
            S_IDLE:    ready_d = 1'b1;
            S_HEADER: begin
                pv_d   = 1'b1;
                data_d = hdr_d;
            end
            S_PAYLOAD: begin
                pv_d   = 1'b1;
                data_d = mem[rd_idx_d];
            end
            S_PARITY:  data_d = par_d;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            len_q        <= 6'd0;
            wr_idx_q     <= 6'd0;
            rd_idx_q     <= 6'd0;
            hdr_q        <= 8'h00;
            par_q        <= 8'h00;
            gap_q        <= 4'd0;
            packet_valid <= 1'b0;
            pkt_data     <= 8'h00;
            ready        <= 1'b1;
            done         <= 1'b0;
            reject       <= 1'b0;
            err_flag     <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            hdr_q        <= hdr_d;
            par_q        <= par_d;
            gap_q        <= gap_d;
            packet_valid <= pv_d;
            pkt_data     <= data_d;
            ready        <= ready_d;
            done         <= done_d;
            reject       <= reject_d;
            err_flag     <= err_flag_d;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed packets plus randomized packets checked
// against an expected byte stream built from the packet format rules.
module tb_router_pkt_tx;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dest = 2'd0;
    logic [5:0] len = 6'd0;
    logic       pl_wr = 1'b0;
    logic [7:0] pl_data = 8'h00;
    logic       busy = 1'b0;
    logic       err = 1'b0;
    logic       packet_valid;
    logic [7:0] pkt_data;
    logic       ready;
    logic       done;
    logic       reject;
    logic       err_flag;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       pv;
        logic [7:0] d;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] pl_buf [64];
    logic       exp_eflag = 1'b0;

    router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .dest(dest),
        .len(len),
        .pl_wr(pl_wr),
        .pl_data(pl_data),
        .busy(busy),
        .err(err),
        .packet_valid(packet_valid),
        .pkt_data(pkt_data),
        .ready(ready),
        .done(done),
        .reject(reject),
        .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full packet; payload comes from pl_buf. stall_at/stall_n force busy
    // while beat stall_at is shown; abort_at resets while that beat is shown.
    task automatic run_pkt(input logic [1:0] d, input logic [5:0] l,
                           input bit rnd_busy, input int stall_at,
                           input int stall_n, input int err_mode,
                           input int abort_at);
        logic [7:0] hdr;
        logic [7:0] par;
        int idx;
        int sc;
        int budget;
        bit err_any;
        beat_t b;
        hdr = {l, d};
        par = hdr;
        exp_q.delete();
        exp_q.push_back('{1'b1, hdr});
        for (int i = 0; i < int'(l); i++) begin
            par ^= pl_buf[i];
            exp_q.push_back('{1'b1, pl_buf[i]});
        end
        exp_q.push_back('{1'b0, par});

        start = 1'b1;
        dest  = d;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        chk("accept_ready", ready, 0);
        chk("accept_eflag", err_flag, 0);
        exp_eflag = 1'b0;

        for (int i = 0; i < int'(l); i++) begin
            while ($urandom_range(3) == 0) begin
                pl_wr   = 1'b0;
                pl_data = 8'($urandom);
                busy    = 1'($urandom);
                start   = 1'($urandom);
                dest    = 2'($urandom);
                len     = 6'($urandom);
                @(negedge clk);
                chk("load_pv", packet_valid, 0);
                chk("load_ready", ready, 0);
            end
            pl_wr   = 1'b1;
            pl_data = pl_buf[i];
            busy    = 1'($urandom);
            start   = 1'($urandom);
            @(negedge clk);
        end

        idx = 0;
        sc = 0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 1000) begin
            b = exp_q[0];
            chk("tx_pv", packet_valid, b.pv);
            chk("tx_data", pkt_data, b.d);
            chk("tx_ready", ready, 0);
            if (abort_at >= 0 && idx == abort_at) begin
                #2 resetn = 1'b0;
                #1;
                chk("abort_pv", packet_valid, 0);
                chk("abort_data", pkt_data, 0);
                chk("abort_ready", ready, 1);
                chk("abort_eflag", err_flag, 0);
                pl_wr = 1'b0;
                busy  = 1'b0;
                start = 1'b0;
                err   = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
                exp_eflag = 1'b0;
                exp_q.delete();
                return;
            end
            if (idx == stall_at && sc < stall_n) begin
                busy = 1'b1;
                sc++;
            end else begin
                busy = rnd_busy ? ($urandom_range(3) == 0) : 1'b0;
            end
            pl_wr   = 1'($urandom);
            pl_data = 8'($urandom);
            start   = 1'($urandom);
            err     = (err_mode == 1) ? 1'($urandom) : 1'b0;
            @(negedge clk);
            if (!busy) begin
                void'(exp_q.pop_front());
                idx++;
            end
            budget++;
        end
        if (exp_q.size() != 0) chk("tx_timeout", exp_q.size(), 0);

        err_any = 1'b0;
        for (int g = 0; g < GAP; g++) begin
            chk("gap_pv", packet_valid, 0);
            chk("gap_data", pkt_data, 0);
            chk("gap_done", done, 0);
            chk("gap_ready", ready, 0);
            start = 1'b0;
            busy  = 1'($urandom);
            if (err_mode == 1) err = 1'($urandom);
            else err = (err_mode == 2 && g == 0);
            err_any |= err;
            @(negedge clk);
        end
        err   = 1'b0;
        pl_wr = 1'b0;
        chk("end_done", done, 1);
        chk("end_ready", ready, 1);
        chk("end_eflag", err_flag, err_any);
        exp_eflag = err_any;
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_ready", ready, 1);
        chk("idle_eflag", err_flag, exp_eflag);
    endtask

    task automatic illegal(input logic [1:0] d, input logic [5:0] l);
        start = 1'b1;
        dest  = d;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        chk("rej_pulse", reject, 1);
        chk("rej_ready", ready, 1);
        chk("rej_pv", packet_valid, 0);
        chk("rej_eflag", err_flag, exp_eflag);
        pl_wr   = 1'b1;
        pl_data = 8'hA5;
        @(negedge clk);
        pl_wr = 1'b0;
        chk("rej_clear", reject, 0);
        chk("rej_ready2", ready, 1);
        chk("rej_pv2", packet_valid, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pv", packet_valid, 0);
        chk("rst_data", pkt_data, 0);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_reject", reject, 0);
        chk("rst_eflag", err_flag, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_ready0", ready, 1);

        pl_buf[0] = 8'h11;
        pl_buf[1] = 8'h22;
        pl_buf[2] = 8'h33;
        run_pkt(2'd1, 6'd3, 1'b0, -1, 0, 0, -1);
        run_pkt(2'd1, 6'd3, 1'b0, 1, 3, 0, -1);

        illegal(2'd3, 6'd5);
        illegal(2'd1, 6'd0);

        run_pkt(2'd1, 6'd3, 1'b0, -1, 0, 2, -1);
        repeat (3) begin
            @(negedge clk);
            chk("sticky_eflag", err_flag, 1);
        end
        illegal(2'd3, 6'd0);

        pl_buf[0] = 8'h5C;
        run_pkt(2'd0, 6'd1, 1'b1, -1, 0, 0, -1);

        for (int i = 0; i < 63; i++) pl_buf[i] = 8'(i);
        run_pkt(2'd2, 6'd63, 1'b0, -1, 0, 0, -1);

        for (int i = 0; i < 10; i++) pl_buf[i] = 8'($urandom);
        run_pkt(2'd0, 6'd10, 1'b0, -1, 0, 0, 6);
        for (int i = 0; i < 5; i++) pl_buf[i] = 8'($urandom);
        run_pkt(2'd2, 6'd5, 1'b0, -1, 0, 0, -1);

        repeat (25) begin
            logic [1:0] d;
            logic [5:0] l;
            d = 2'($urandom_range(2));
            l = 6'($urandom_range(63, 1));
            for (int i = 0; i < 64; i++) pl_buf[i] = 8'($urandom);
            if ($urandom_range(4) == 0) illegal(2'd3, l);
            run_pkt(d, l, 1'b1, -1, 0, 1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
